// File: rtl/player_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : player_motion_ctrl
// Description : Kinematics engine for one player. Converts held buttons into
//               on-screen (x,y) and pose flags once per frame tick. Supports
//               parametrised jump physics, multi-jump, a post-landing
//               lock-out and hit-stun.
//
// Ports       : clk      - system clock
//               rst      - asynchronous, active-high reset
//               tick     - frame strobe; state advances only when high
//               right    - move right (held), wins over left
//               left     - move left (held)
//               jump     - jump button level; a rising edge launches
//               squat    - squat (held)
//               defend   - defend (held); blocks incoming hits
//               hit      - hit from collision unit, sampled on tick
//               hit_dir  - 0 = pushed left, 1 = pushed right
//               x, y     - signed player position
//               isD/isQ/isJ - defending / squatting / airborne
//               st       - 0 GROUND, 1 AIR, 2 LAND, 3 STUN
//
// Config      : define PLAYER_KNOCKBACK_EN to push x by KB_STEP per tick
//               toward hit_dir while stunned; otherwise x is frozen during
//               stun and hit_dir is ignored.
//
// Revision    : 1.0 - initial release
// ============================================================================
module player_motion_ctrl #(
    parameter int XW         = 11,
    parameter int YW         = 10,
    parameter int STEP_X     = 4,
    parameter int X_MIN      = -288,
    parameter int X_MAX      = 288,
    parameter int Y_GND      = -208,
    parameter int V0         = 20,
    parameter int G          = 2,
    parameter int AIR_JUMPS  = 1,
    parameter int LAND_LOCK  = 3,
    parameter int STUN_TICKS = 8,
    parameter int KB_STEP    = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 right,
    input  logic                 left,
    input  logic                 jump,
    input  logic                 squat,
    input  logic                 defend,
    input  logic                 hit,
    input  logic                 hit_dir,
    output logic signed [XW-1:0] x,
    output logic signed [YW-1:0] y,
    output logic                 isD,
    output logic                 isQ,
    output logic                 isJ,
    output logic [1:0]           st
);

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_AIR    = 2'd1,
        ST_LAND   = 2'd2,
        ST_STUN   = 2'd3
    } state_t;

    // Arc counter saturation point; reaching it forces a landing so a
    // mis-tuned V0/G pair can never leave the player floating forever.
    localparam int c_JCNT_SAT = 63;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t                r_st;
    logic signed [XW-1:0]  r_x;
    logic signed [YW-1:0]  r_y;
    logic signed [YW-1:0]  r_y_base;
    logic [5:0]            r_jcnt;
    logic [7:0]            r_air_used;
    logic [7:0]            r_lock;
    logic [7:0]            r_scnt;
    logic                  r_stun_air;
    logic                  r_jump_q;
    logic                  r_isD;
    logic                  r_isQ;
    logic                  r_isJ;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t                w_st_n;
    logic signed [XW-1:0]  w_x_n;
    logic signed [YW-1:0]  w_y_n;
    logic signed [YW-1:0]  w_y_base_n;
    logic [5:0]            w_jcnt_n;
    logic [7:0]            w_air_used_n;
    logic [7:0]            w_lock_n;
    logic [7:0]            w_scnt_n;
    logic                  w_stun_air_n;
    logic                  w_isD_n;
    logic                  w_isQ_n;
    logic                  w_isJ_n;

    logic                  w_jump_rise;
    logic                  w_hit_take;
    int                    w_move;
    logic signed [XW-1:0]  w_x_move;
    int                    w_j;
    int                    w_y_arc;
    logic                  w_arc_land;

    // Adds delta to x in a widened domain so the clamp sees true overflow
    // rather than a wrapped value.
    function automatic logic signed [XW-1:0] f_clamp_x(
        input logic signed [XW-1:0] xi,
        input int                   delta
    );
        logic signed [XW+1:0] v;
        v = (XW+2)'(xi) + (XW+2)'(delta);
        if (v > (XW+2)'(X_MAX)) begin
            v = (XW+2)'(X_MAX);
        end else if (v < (XW+2)'(X_MIN)) begin
            v = (XW+2)'(X_MIN);
        end
        return v[XW-1:0];
    endfunction

    assign w_jump_rise = jump & ~r_jump_q;
    assign w_hit_take  = hit & ~defend & (r_st != ST_STUN);
    assign w_move      = right ? STEP_X : (left ? -STEP_X : 0);
    assign w_x_move    = f_clamp_x(r_x, w_move);

    // Closed-form ballistic arc relative to the launch height. The halving
    // is an arithmetic shift so the sub-pixel term rounds toward -inf.
    assign w_j        = int'(r_jcnt) + 1;
    assign w_y_arc    = int'(r_y_base) + V0 * w_j - ((G * w_j * w_j) >>> 1);
    assign w_arc_land = (w_y_arc <= Y_GND) || (w_j >= c_JCNT_SAT);

`ifndef PLAYER_KNOCKBACK_EN
    logic w_unused_hit_dir;
    assign w_unused_hit_dir = hit_dir;
`endif

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_st_n       = r_st;
        w_x_n        = r_x;
        w_y_n        = r_y;
        w_y_base_n   = r_y_base;
        w_jcnt_n     = r_jcnt;
        w_air_used_n = r_air_used;
        w_lock_n     = r_lock;
        w_scnt_n     = r_scnt;
        w_stun_air_n = r_stun_air;

        if (w_hit_take) begin
            // Hit beats a simultaneous jump press; position holds on the
            // entry tick and the arc (if any) resumes on the next tick.
            w_st_n       = ST_STUN;
            w_scnt_n     = 8'(STUN_TICKS);
            w_stun_air_n = (r_st == ST_AIR);
        end else begin
            case (r_st)
                ST_GROUND: begin
                    w_x_n = w_x_move;
                    if (w_jump_rise) begin
                        w_st_n       = ST_AIR;
                        w_y_base_n   = r_y;
                        w_jcnt_n     = 6'd0;
                        w_air_used_n = 8'd0;
                    end else begin
                        w_y_n = YW'(Y_GND);
                    end
                end

                ST_AIR: begin
                    w_x_n = w_x_move;
                    if (w_jump_rise && (int'(r_air_used) < AIR_JUMPS)) begin
                        // Restart the arc from the current height; the arc
                        // is not evaluated on this tick.
                        w_y_base_n   = r_y;
                        w_jcnt_n     = 6'd0;
                        w_air_used_n = r_air_used + 8'd1;
                    end else if (w_arc_land) begin
                        w_y_n    = YW'(Y_GND);
                        w_st_n   = ST_LAND;
                        w_lock_n = 8'(LAND_LOCK);
                    end else begin
                        w_y_n    = w_y_arc[YW-1:0];
                        w_jcnt_n = r_jcnt + 6'd1;
                    end
                end

                ST_LAND: begin
                    w_x_n = w_x_move;
                    // Leave once the lock-out has run down to zero.
                    if (r_lock <= 8'd1) begin
                        w_lock_n = 8'd0;
                        w_st_n   = ST_GROUND;
                    end else begin
                        w_lock_n = r_lock - 8'd1;
                    end
                end

                ST_STUN: begin
`ifdef PLAYER_KNOCKBACK_EN
                    w_x_n = f_clamp_x(r_x, hit_dir ? KB_STEP : -KB_STEP);
`endif
                    // An airborne stun keeps falling; touching down just
                    // clears the flag without passing through LAND.
                    if (r_stun_air) begin
                        if (w_arc_land) begin
                            w_y_n        = YW'(Y_GND);
                            w_stun_air_n = 1'b0;
                        end else begin
                            w_y_n    = w_y_arc[YW-1:0];
                            w_jcnt_n = r_jcnt + 6'd1;
                        end
                    end
                    if (r_scnt <= 8'd1) begin
                        w_scnt_n = 8'd0;
                        w_st_n   = w_stun_air_n ? ST_AIR : ST_GROUND;
                    end else begin
                        w_scnt_n = r_scnt - 8'd1;
                    end
                end

                default: begin
                    w_st_n = ST_GROUND;
                end
            endcase
        end

        // Pose flags follow the state being entered on this tick.
        w_isQ_n = squat & ((w_st_n == ST_GROUND) || (w_st_n == ST_LAND));
        w_isD_n = defend & (w_st_n != ST_STUN);
        w_isJ_n = (w_st_n == ST_AIR) || ((w_st_n == ST_STUN) && w_stun_air_n);
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st       <= ST_GROUND;
            r_x        <= XW'(X_MIN);
            r_y        <= YW'(Y_GND);
            r_y_base   <= YW'(Y_GND);
            r_jcnt     <= 6'd0;
            r_air_used <= 8'd0;
            r_lock     <= 8'd0;
            r_scnt     <= 8'd0;
            r_stun_air <= 1'b0;
            r_jump_q   <= 1'b0;
            r_isD      <= 1'b0;
            r_isQ      <= 1'b0;
            r_isJ      <= 1'b0;
        end else if (tick) begin
            r_st       <= w_st_n;
            r_x        <= w_x_n;
            r_y        <= w_y_n;
            r_y_base   <= w_y_base_n;
            r_jcnt     <= w_jcnt_n;
            r_air_used <= w_air_used_n;
            r_lock     <= w_lock_n;
            r_scnt     <= w_scnt_n;
            r_stun_air <= w_stun_air_n;
            r_jump_q   <= jump;
            r_isD      <= w_isD_n;
            r_isQ      <= w_isQ_n;
            r_isJ      <= w_isJ_n;
        end
    end

    assign x   = r_x;
    assign y   = r_y;
    assign st  = r_st;
    assign isD = r_isD;
    assign isQ = r_isQ;
    assign isJ = r_isJ;

endmodule
`default_nettype wire
